// File: rtl/ram_sp_clr.sv
// ram_sp_clr -- scratch/data memory with a built-in clear engine.
//
// Purpose:
//   DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits, one write port with
//   per-byte enables and one registered read port with a valid strobe.
//   After reset, or on Clear_req, a sweep writes CLEAR_VALUE to every word
//   (one word per cycle, address 0 upward). The memory array itself has no
//   reset; the sweep is what initialises it.
//
// Ports:
//   CLK         in   1             sole clock, rising edge
//   RST         in   1             asynchronous, active-high reset
//   Write_en    in   1             write request (ignored while Busy)
//   Write_ADDR  in   ADDR_WIDTH    write address
//   Write_Data  in   DATA_WIDTH    write data
//   Write_mask  in   DATA_WIDTH/8  byte enables, bit i -> bits 8i+7:8i
//   Read_en     in   1             read request (ignored while Busy)
//   Read_ADDR   in   ADDR_WIDTH    read address
//   Read_Data   out  DATA_WIDTH    registered read data, holds when idle
//   Read_valid  out  1             one cycle after each accepted read
//   Clear_req   in   1             start a full sweep (ignored while Busy)
//   Busy        out  1             clear sweep in progress
//
// Build option:
//   RAM_WR_FORWARD_EN -- when defined, a read and write to the same address
//   in the same cycle return the merged (post-write) word; otherwise the read
//   returns the pre-write word. Memory holds the new data either way.
//
// States:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_CLEAR  | sweeping CLEAR_VALUE into mem[clr_ptr]; ports ignored
//   ST_READY  | normal read/write service; Clear_req restarts the sweep

module ram_sp_clr #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 7,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Write_en,
    input  logic [ADDR_WIDTH-1:0]   Write_ADDR,
    input  logic [DATA_WIDTH-1:0]   Write_Data,
    input  logic [DATA_WIDTH/8-1:0] Write_mask,
    input  logic                    Read_en,
    input  logic [ADDR_WIDTH-1:0]   Read_ADDR,
    output logic [DATA_WIDTH-1:0]   Read_Data,
    output logic                    Read_valid,
    input  logic                    Clear_req,
    output logic                    Busy
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_width_check
        $error("ram_sp_clr: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [ADDR_WIDTH-1:0]   clr_ptr_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    ready;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word;

    // ------------------------------------------------------------------
    // Sweep controller
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            ST_CLEAR: begin
                // Pointer wraps to 0 on the last word, so it is already
                // parked at 0 for the next sweep.
                clr_ptr_next = clr_ptr + ADDR_WIDTH'(1);
                if (clr_ptr == LAST_ADDR) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (Clear_req) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    // Busy comes straight off the state flop: no input-to-output path.
    assign Busy    = (state == ST_CLEAR);
    assign ready   = (state == ST_READY);
    assign wr_fire = ready && Write_en;
    assign rd_fire = ready && Read_en;

    // ------------------------------------------------------------------
    // Storage: the sweep has priority; user writes only land in READY.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!ready) begin
            mem[clr_ptr] <= CLEAR_VALUE;
        end else if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (Write_mask[i]) begin
                    mem[Write_ADDR][8*i +: 8] <= Write_Data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
`ifdef RAM_WR_FORWARD_EN
    // Same-cycle same-address write: overlay the enabled new bytes on the
    // stored word so the read sees what memory will hold after this edge.
    always_comb begin
        rd_word = mem[Read_ADDR];
        if (wr_fire && (Write_ADDR == Read_ADDR)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (Write_mask[i]) begin
                    rd_word[8*i +: 8] = Write_Data[8*i +: 8];
                end
            end
        end
    end
`else
    // Read-before-write: the array is sampled before this edge's update.
    assign rd_word = mem[Read_ADDR];
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Read_Data  <= '0;
            Read_valid <= 1'b0;
        end else begin
            Read_valid <= rd_fire;
            if (rd_fire) begin
                Read_Data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Self-checking bench for ram_sp_clr (default parameters: 16-bit x 128).
// Directed table vectors, hand-written clear/reset sequences and a random
// phase, all cross-checked every cycle against a word-array reference model.

module tb_ram_sp_clr;

    localparam int          DW    = 16;
    localparam int          AW    = 7;
    localparam int          MW    = DW / 8;
    localparam int          DEPTH = 2 ** AW;
    localparam logic [DW-1:0] CLR_VAL = '0;
`ifdef RAM_WR_FORWARD_EN
    localparam bit          FWD   = 1'b1;
`else
    localparam bit          FWD   = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic          Write_en;
    logic [AW-1:0] Write_ADDR;
    logic [DW-1:0] Write_Data;
    logic [MW-1:0] Write_mask;
    logic          Read_en;
    logic [AW-1:0] Read_ADDR;
    logic [DW-1:0] Read_Data;
    logic          Read_valid;
    logic          Clear_req;
    logic          Busy;

    ram_sp_clr #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .CLEAR_VALUE (CLR_VAL)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Write_en   (Write_en),
        .Write_ADDR (Write_ADDR),
        .Write_Data (Write_Data),
        .Write_mask (Write_mask),
        .Read_en    (Read_en),
        .Read_ADDR  (Read_ADDR),
        .Read_Data  (Read_Data),
        .Read_valid (Read_valid),
        .Clear_req  (Clear_req),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain word array plus "words still to sweep".
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_left;
    logic [DW-1:0] m_rd;
    logic          m_valid;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        logic          re;
        logic [AW-1:0] raddr;
        logic          exp_valid;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        Write_en   = 1'b0;
        Write_ADDR = '0;
        Write_Data = '0;
        Write_mask = '0;
        Read_en    = 1'b0;
        Read_ADDR  = '0;
        Clear_req  = 1'b0;
    endtask

    task automatic model_reset();
        m_clear_left = DEPTH;
        m_rd         = '0;
        m_valid      = 1'b0;
    endtask

    // Advance the model by the inputs currently driven, clock the DUT, then
    // compare all three observable outputs.
    task automatic cycle();
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = CLR_VAL;
            m_clear_left = m_clear_left - 1;
            m_valid = 1'b0;
        end else begin
            old_w = m_mem[Read_ADDR];
            if (Write_en) begin
                new_w = m_mem[Write_ADDR];
                for (int i = 0; i < MW; i++)
                    if (Write_mask[i]) new_w[8*i +: 8] = Write_Data[8*i +: 8];
                m_mem[Write_ADDR] = new_w;
            end
            if (Read_en) begin
                m_valid = 1'b1;
                if (FWD && Write_en && (Write_ADDR == Read_ADDR)) m_rd = m_mem[Read_ADDR];
                else m_rd = old_w;
            end else begin
                m_valid = 1'b0;
            end
            if (Clear_req) m_clear_left = DEPTH;
        end
        @(posedge CLK);
        #1;
        check("model_busy",  {31'd0, Busy},       {31'd0, (m_clear_left > 0)});
        check("model_valid", {31'd0, Read_valid}, {31'd0, m_valid});
        check("model_rdata", {16'd0, Read_Data},  {16'd0, m_rd});
    endtask

    // Run idle cycles until Busy drops; compare the number of cycles taken.
    task automatic wait_idle(input int exp_cycles);
        int n;
        n = 0;
        set_idle();
        while (Busy && n < 400) begin
            cycle();
            n++;
        end
        check("clear_length", n, exp_cycles);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        set_idle();
        Read_en   = 1'b1;
        Read_ADDR = a;
        cycle();
        check(name, {16'd0, Read_Data}, {16'd0, exp});
        check({name, "_valid"}, {31'd0, Read_valid}, 32'd1);
    endtask

    task automatic apply_reset_checked();
        RST = 1'b1;
        #1;
        check("rst_busy",  {31'd0, Busy},       32'd1);
        check("rst_valid", {31'd0, Read_valid}, 32'd0);
        check("rst_rdata", {16'd0, Read_Data},  32'd0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hold_busy", {31'd0, Busy}, 32'd1);
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // dir vectors: we waddr wdata wmask re raddr | exp_valid exp_rd
        tbl[0]  = '{1'b1, 7'd3,  16'hDBDB, 2'b11, 1'b0, 7'd0,  1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 7'd7,  16'hAAAA, 2'b11, 1'b0, 7'd0,  1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 7'd0,  16'h0000, 2'b00, 1'b1, 7'd3,  1'b1, 16'hDBDB};
        tbl[3]  = '{1'b0, 7'd0,  16'h0000, 2'b00, 1'b1, 7'd7,  1'b1, 16'hAAAA};
        tbl[4]  = '{1'b0, 7'd0,  16'h0000, 2'b00, 1'b0, 7'd0,  1'b0, 16'hAAAA};
        tbl[5]  = '{1'b1, 7'd3,  16'h1234, 2'b01, 1'b0, 7'd0,  1'b0, 16'hAAAA};
        tbl[6]  = '{1'b0, 7'd0,  16'h0000, 2'b00, 1'b1, 7'd3,  1'b1, 16'hDB34};
        tbl[7]  = '{1'b1, 7'd3,  16'h1234, 2'b00, 1'b0, 7'd0,  1'b0, 16'hDB34};
        tbl[8]  = '{1'b0, 7'd0,  16'h0000, 2'b00, 1'b1, 7'd3,  1'b1, 16'hDB34};
        tbl[9]  = '{1'b1, 7'd10, 16'h5555, 2'b11, 1'b1, 7'd10, 1'b1, FWD ? 16'h5555 : 16'h0000};
        tbl[10] = '{1'b0, 7'd0,  16'h0000, 2'b00, 1'b1, 7'd10, 1'b1, 16'h5555};

        set_idle();
        RST = 1'b1;
        m_rd = '0;
        m_valid = 1'b0;

        // 1: reset values, exact clear length, first read
        apply_reset_checked();
        wait_idle(DEPTH);
        do_read(7'd5, 16'h0000, "t1_read5");
        set_idle();
        cycle();
        check("t1_valid_drop", {31'd0, Read_valid}, 32'd0);

        // 2-4: directed table
        for (int k = 0; k < 11; k++) begin
            set_idle();
            Write_en   = tbl[k].we;
            Write_ADDR = tbl[k].waddr;
            Write_Data = tbl[k].wdata;
            Write_mask = tbl[k].wmask;
            Read_en    = tbl[k].re;
            Read_ADDR  = tbl[k].raddr;
            cycle();
            check($sformatf("tbl%0d_valid", k), {31'd0, Read_valid}, {31'd0, tbl[k].exp_valid});
            check($sformatf("tbl%0d_rdata", k), {16'd0, Read_Data},  {16'd0, tbl[k].exp_rd});
        end

        // 5: clear request, write during Busy dropped, Read_Data held
        set_idle();
        Clear_req = 1'b1;
        cycle();
        check("t5_busy_rise", {31'd0, Busy}, 32'd1);
        set_idle();
        Write_en   = 1'b1;
        Write_ADDR = 7'd3;
        Write_Data = 16'hFFFF;
        Write_mask = 2'b11;
        Read_en    = 1'b1;
        Read_ADDR  = 7'd3;
        Clear_req  = 1'b1;
        cycle();
        check("t5_read_ignored", {31'd0, Read_valid}, 32'd0);
        wait_idle(DEPTH - 1);
        check("t5_rdata_held", {16'd0, Read_Data}, 32'h5555);
        do_read(7'd3, 16'h0000, "t5_read3");
        do_read(7'd7, 16'h0000, "t5_read7");

        // random traffic on a narrow address window to force collisions
        for (int k = 0; k < 600; k++) begin
            Write_en   = 1'($urandom_range(0, 1));
            Write_ADDR = AW'($urandom_range(0, 15));
            Write_Data = DW'($urandom);
            Write_mask = MW'($urandom_range(0, 3));
            Read_en    = 1'($urandom_range(0, 1));
            Read_ADDR  = ($urandom_range(0, 3) == 0) ? Write_ADDR : AW'($urandom_range(0, 15));
            Clear_req  = ($urandom_range(0, 99) == 0);
            cycle();
        end
        set_idle();
        for (int k = 0; k < 200 && Busy; k++) cycle();
        check("rand_drained", {31'd0, Busy}, 32'd0);

        // 6: reset mid-clear
        set_idle();
        Write_en   = 1'b1;
        Write_ADDR = 7'd20;
        Write_Data = 16'h5A5A;
        Write_mask = 2'b11;
        cycle();
        do_read(7'd20, 16'h5A5A, "t6_pre_read");
        set_idle();
        Clear_req = 1'b1;
        cycle();
        set_idle();
        repeat (40) cycle();
        check("t6_midclear_busy", {31'd0, Busy}, 32'd1);
        apply_reset_checked();
        wait_idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            set_idle();
            Read_en   = 1'b1;
            Read_ADDR = AW'(a);
            cycle();
            check($sformatf("t6_read%0d", a), {16'd0, Read_Data}, 32'h0000);
        end
        set_idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
